// File: rtl/fetch_sequencer.sv
// Multicycle instruction fetch controller: requests words from instruction memory,
// strobes the instruction register, and halts with a sticky fault code on errors.
module fetch_sequencer #(
    parameter int unsigned                PC_WIDTH = 64,
    parameter logic [PC_WIDTH-1:0]        RESET_PC = '0,
    parameter int unsigned                TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic                imem_err,
    output logic                load_ir,
    output logic                instr_valid,
    input  logic                exec_done,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    output logic [PC_WIDTH-1:0] pc,
    output logic                busy,
    output logic                fault,
    output logic [1:0]          fault_code
);

    // Counter only has to reach TIMEOUT-1, the last cycle in which an ack is accepted.
    localparam int unsigned    CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [PC_WIDTH-1:0] r_pc;
    logic [CW-1:0]       r_cnt;
    logic [1:0]          r_code;
    logic [PC_WIDTH-1:0] w_target;

    assign w_target = redirect ? redirect_pc : r_pc + PC_WIDTH'(4);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_pc       <= '0;
            r_cnt      <= '0;
            r_code     <= 2'b00;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_REQ;
                        r_cnt   <= '0;
                    end
                end
                S_REQ: begin
                    if (imem_err) begin
                        r_state <= S_HALT;
                        r_code  <= 2'b01;
                    end else if (imem_ack) begin
                        r_pc    <= r_fetch_pc;
                        r_state <= S_EXEC;
                    end else if ((TIMEOUT != 0) && (r_cnt == LAST)) begin
                        r_state <= S_HALT;
                        r_code  <= 2'b10;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (exec_done) begin
                        if (w_target[1:0] != 2'b00) begin
                            r_state <= S_HALT;
                            r_code  <= 2'b11;
                        end else begin
                            r_fetch_pc <= w_target;
                            r_cnt      <= '0;
                            r_state    <= S_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Outputs decode the state register directly so reset clears them immediately.
    assign imem_req    = (r_state == S_REQ);
    assign imem_addr   = imem_req ? r_fetch_pc : '0;
    assign load_ir     = imem_req && imem_ack && !imem_err;
    assign instr_valid = (r_state == S_EXEC);
    assign busy        = (r_state == S_REQ) || (r_state == S_EXEC);
    assign fault       = (r_state == S_HALT);
    assign fault_code  = r_code;
    assign pc          = r_pc;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential fetch, redirect, timeout,
// bus error priority, PC wrap and mid-operation reset.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic        imem_err;
    logic        load_ir;
    logic        instr_valid;
    logic        exec_done;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic [63:0] pc;
    logic        busy;
    logic        fault;
    logic [1:0]  fault_code;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    fetch_sequencer #(
        .PC_WIDTH (64),
        .RESET_PC (64'h0),
        .TIMEOUT  (4)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_err    (imem_err),
        .load_ir     (load_ir),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .busy        (busy),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start       = 1'b0;
        imem_ack    = 1'b0;
        imem_err    = 1'b0;
        exec_done   = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 64'h0;
        reset_n     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        cyc();
        check("rst_req",   64'(imem_req),    64'd0);
        check("rst_addr",  imem_addr,        64'h0);
        check("rst_busy",  64'(busy),        64'd0);
        check("rst_fault", 64'(fault),       64'd0);
        check("rst_code",  64'(fault_code),  64'd0);
        check("rst_pc",    pc,               64'h0);
        check("rst_valid", 64'(instr_valid), 64'd0);
        check("rst_ldir",  64'(load_ir),     64'd0);

        // Sequential fetch with ack on the third REQ cycle.
        do_start();
        check("st_req",  64'(imem_req), 64'd1);
        check("st_addr", imem_addr,     64'h0);
        check("st_busy", 64'(busy),     64'd1);
        for (int i = 0; i < 2; i++) begin
            check("wait_ldir", 64'(load_ir), 64'd0);
            cyc();
            check("wait_addr", imem_addr, 64'h0);
        end
        imem_ack = 1'b1;
        #1;
        check("ack_ldir", 64'(load_ir), 64'd1);
        cyc();
        imem_ack = 1'b0;
        #1;
        check("ex_ldir",  64'(load_ir),     64'd0);
        check("ex_valid", 64'(instr_valid), 64'd1);
        check("ex_pc",    pc,               64'h0);
        check("ex_req",   64'(imem_req),    64'd0);
        redirect    = 1'b1;
        redirect_pc = 64'h2000;
        cyc();
        check("ex_hold_valid", 64'(instr_valid), 64'd1);
        redirect  = 1'b0;
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;
        check("seq4_valid", 64'(instr_valid), 64'd0);
        check("seq4_req",   64'(imem_req),    64'd1);
        check("seq4_addr",  imem_addr,        64'h4);
        imem_ack = 1'b1;
        cyc();
        imem_ack  = 1'b0;
        check("seq4_pc", pc, 64'h4);
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;
        check("seq8_addr", imem_addr, 64'h8);

        // Redirect to an aligned target, then to a misaligned one.
        imem_ack = 1'b1;
        cyc();
        imem_ack    = 1'b0;
        check("seq8_pc", pc, 64'h8);
        exec_done   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h1000;
        cyc();
        exec_done = 1'b0;
        redirect  = 1'b0;
        check("redir_addr", imem_addr, 64'h1000);
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        check("redir_pc", pc, 64'h1000);
        exec_done   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'h1002;
        cyc();
        exec_done = 1'b0;
        redirect  = 1'b0;
        check("mis_fault", 64'(fault),      64'd1);
        check("mis_code",  64'(fault_code), 64'd3);
        check("mis_req",   64'(imem_req),   64'd0);
        check("mis_busy",  64'(busy),       64'd0);
        check("mis_pc",    pc,              64'h1000);
        start = 1'b1;
        cyc();
        start = 1'b0;
        check("halt_start_req", 64'(imem_req), 64'd0);
        check("halt_start_flt", 64'(fault),    64'd1);

        // Timeout: no response for four REQ cycles.
        do_reset();
        do_start();
        for (int i = 0; i < 4; i++) begin
            check("to_req", 64'(imem_req), 64'd1);
            cyc();
        end
        check("to_req_low", 64'(imem_req),   64'd0);
        check("to_fault",   64'(fault),      64'd1);
        check("to_code",    64'(fault_code), 64'd2);

        // Ack in the final allowed cycle is accepted.
        do_reset();
        do_start();
        repeat (3) cyc();
        check("to4_req", 64'(imem_req), 64'd1);
        imem_ack = 1'b1;
        #1;
        check("to4_ldir", 64'(load_ir), 64'd1);
        cyc();
        imem_ack = 1'b0;
        check("to4_fault", 64'(fault),       64'd0);
        check("to4_valid", 64'(instr_valid), 64'd1);

        // Bus error wins over a simultaneous ack; HALT is sticky.
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;
        imem_err  = 1'b1;
        imem_ack  = 1'b1;
        #1;
        check("err_ldir", 64'(load_ir), 64'd0);
        cyc();
        imem_err = 1'b0;
        imem_ack = 1'b0;
        check("err_fault", 64'(fault),      64'd1);
        check("err_code",  64'(fault_code), 64'd1);
        check("err_req",   64'(imem_req),   64'd0);
        check("err_pc",    pc,              64'h0);
        repeat (3) cyc();
        check("err_sticky", 64'(fault_code), 64'd1);
        do_reset();
        #1;
        check("err_rst_fault", 64'(fault),      64'd0);
        check("err_rst_code",  64'(fault_code), 64'd0);

        // PC wrap through 2^64.
        do_start();
        imem_ack = 1'b1;
        cyc();
        imem_ack    = 1'b0;
        exec_done   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        cyc();
        exec_done = 1'b0;
        redirect  = 1'b0;
        check("wrap_req_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        imem_ack = 1'b1;
        cyc();
        imem_ack = 1'b0;
        check("wrap_pc", pc, 64'hFFFF_FFFF_FFFF_FFFC);
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;
        check("wrap_addr",  imem_addr,     64'h0);
        check("wrap_req",   64'(imem_req), 64'd1);
        check("wrap_fault", 64'(fault),    64'd0);

        // Reset asserted mid-request drops imem_req without waiting for a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        check("mid_rst_req",  64'(imem_req), 64'd0);
        check("mid_rst_busy", 64'(busy),     64'd0);
        check("mid_rst_pc",   pc,            64'h0);
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        check("mid_rst_idle", 64'(imem_req), 64'd0);
        do_start();
        check("mid_rst_restart_addr", imem_addr, 64'h0);
        check("mid_rst_restart_req",  64'(imem_req), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
